// File: rtl/pot_accumulator.sv
// Saturating batch accumulator for power-of-two shifted products.
// Sums NUM_TERMS signed terms, then holds the result until it is taken.
module pot_accumulator #(
   parameter int PRODUCT_BIT_WIDTH = 20,
   parameter int ACC_BIT_WIDTH     = 22,
   parameter int NUM_TERMS         = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [PRODUCT_BIT_WIDTH-1:0] in_product,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic signed [ACC_BIT_WIDTH-1:0]     out_sum,
   output logic                                out_overflow
);

   localparam int PW = PRODUCT_BIT_WIDTH;
   localparam int AW = ACC_BIT_WIDTH;
   localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);
   localparam logic signed [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                r_state;
   logic signed [AW-1:0]  r_acc;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf;

   logic signed [AW:0]    w_ext;
   logic signed [AW:0]    w_sum;
   logic                  w_pos_sat;
   logic                  w_neg_sat;
   logic signed [AW-1:0]  w_next;
   logic                  w_xfer;

   // One guard bit: the top two bits disagree exactly when the sum leaves range.
   assign w_ext     = {{(AW+1-PW){in_product[PW-1]}}, in_product};
   assign w_sum     = {r_acc[AW-1], r_acc} + w_ext;
   assign w_pos_sat = ~w_sum[AW] & w_sum[AW-1];
   assign w_neg_sat = w_sum[AW] & ~w_sum[AW-1];
   assign w_xfer    = in_valid & (r_state == ACCUM);

   always_comb begin
      w_next = w_sum[AW-1:0];
      unique case (1'b1)
         w_pos_sat: w_next = MAXV;
         w_neg_sat: w_next = MINV;
         default:   w_next = w_sum[AW-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else if (clear) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            ACCUM: begin
               if (w_xfer) begin
                  r_acc <= w_next;
                  r_ovf <= r_ovf | w_pos_sat | w_neg_sat;
                  if (r_cnt == LAST) begin
                     r_cnt   <= '0;
                     r_state <= HOLD;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state <= ACCUM;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign in_ready     = (r_state == ACCUM);
   assign out_valid    = (r_state == HOLD);
   assign out_sum      = r_acc;
   assign out_overflow = r_ovf;

endmodule

// File: tb/tb_pot_accumulator.sv
// Self-checking bench for pot_accumulator: directed table, corner
// sequences and randomized batches against an arithmetic model.
module tb_pot_accumulator;

   localparam longint MAXV = 2097151;
   localparam longint MINV = -2097152;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic signed [19:0] in_product = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic signed [21:0] out_sum;
   logic out_overflow;

   int total = 0;
   int bad = 0;

   pot_accumulator #(
      .PRODUCT_BIT_WIDTH(20),
      .ACC_BIT_WIDTH(22),
      .NUM_TERMS(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_product(in_product),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum),
      .out_overflow(out_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0][19:0]   p;
      logic signed [21:0] s;
      logic               o;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: exact sum clamped to the 22-bit range after every term.
   task automatic model(input logic [7:0][19:0] p,
                        output longint s, output bit o);
      longint acc;
      acc = 0;
      o = 1'b0;
      for (int i = 0; i < 8; i++) begin
         acc = acc + longint'($signed(p[i]));
         if (acc > MAXV) begin
            acc = MAXV;
            o = 1'b1;
         end else if (acc < MINV) begin
            acc = MINV;
            o = 1'b1;
         end
      end
      s = acc;
   endtask

   task automatic batch(input logic [7:0][19:0] p, input longint es,
                        input bit eo, input string nm,
                        input int gmax, input int hold);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, gmax)) begin
            in_valid = 1'b0;
            in_product = 20'($urandom);
            @(posedge clk);
            #1;
         end
         if (i == 7) chk({nm, "_prevalid"}, out_valid, 0);
         in_valid = 1'b1;
         in_product = p[i];
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_product = 20'($urandom);
      end
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_ready"}, in_ready, 0);
      chk({nm, "_sum"}, out_sum, es);
      chk({nm, "_ovf"}, out_overflow, eo);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_product = 20'($urandom);
         @(posedge clk);
         #1;
         chk({nm, "_hold_sum"}, out_sum, es);
         chk({nm, "_hold_ovf"}, out_overflow, eo);
         chk({nm, "_hold_ready"}, in_ready, 0);
      end
      in_valid = 1'b1;
      in_product = 20'sd5;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk({nm, "_rel_valid"}, out_valid, 0);
      chk({nm, "_rel_ready"}, in_ready, 1);
      chk({nm, "_rel_sum"}, out_sum, 0);
      chk({nm, "_rel_ovf"}, out_overflow, 0);
   endtask

   task automatic feed(input int n, input logic signed [19:0] v);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_product = v;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   logic [7:0][19:0] ones;
   logic [7:0][19:0] rp;
   longint es;
   bit eo;

   initial begin
      for (int i = 0; i < 8; i++) ones[i] = 20'sd1;
      for (int i = 0; i < 8; i++) begin
         vecs[0].p[i] = 20'sd65536;
         vecs[1].p[i] = 20'sd0;
         vecs[2].p[i] = 20'sd524287;
         vecs[3].p[i] = 20'sd1;
         vecs[4].p[i] = -20'sd524288;
      end
      vecs[1].p[0] = 20'sd65536;
      vecs[1].p[1] = -20'sd196608;
      vecs[1].p[2] = 20'sd65536;
      vecs[0].s = 22'sd524288;   vecs[0].o = 1'b0;
      vecs[1].s = -22'sd65536;   vecs[1].o = 1'b0;
      vecs[2].s = 22'sd2097151;  vecs[2].o = 1'b1;
      vecs[3].s = 22'sd8;        vecs[3].o = 1'b0;
      vecs[4].s = -22'sd2097152; vecs[4].o = 1'b1;

      #12;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_ovf", out_overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 5; k++)
         batch(vecs[k].p, vecs[k].s, vecs[k].o, $sformatf("vec%0d", k), 0, 0);

      batch(vecs[0].p, vecs[0].s, vecs[0].o, "bp", 0, 5);
      batch(ones, 8, 1'b0, "bp_next", 0, 0);

      feed(3, 20'sd100);
      clear = 1'b1;
      in_valid = 1'b1;
      in_product = 20'sd7;
      @(posedge clk);
      #1;
      clear = 1'b0;
      in_valid = 1'b0;
      chk("clr_sum", out_sum, 0);
      chk("clr_ready", in_ready, 1);
      batch(ones, 8, 1'b0, "clr_next", 0, 0);

      feed(8, 20'sd524287);
      chk("clrh_valid", out_valid, 1);
      clear = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clrh_valid0", out_valid, 0);
      chk("clrh_ovf", out_overflow, 0);
      batch(ones, 8, 1'b0, "clrh_next", 0, 0);

      feed(5, 20'sd1000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sum", out_sum, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      batch(ones, 8, 1'b0, "arst_next", 0, 0);

      for (int b = 0; b < 30; b++) begin
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
               0: rp[i] = 20'sd524287;
               1: rp[i] = -20'sd524288;
               default: rp[i] = 20'($urandom);
            endcase
         end
         model(rp, es, eo);
         batch(rp, es, eo, $sformatf("rnd%0d", b), 2,
               $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
